// File: rtl/buzz_pkg.sv
// buzz_pkg: shared defaults, state type and width helpers for the buzzer driver
package buzz_pkg;
   localparam int CLK_HZ_DEF = 50_000_000;
   localparam int TONE_HZ_DEF = 1000;
   localparam int BEEP_SECS_DEF = 5;
   typedef enum logic {IDLE, BEEP} state_t;
   function automatic int clog2(input int v);
      int r;
      r = 0;
      while ((1 << r) < v) r++;
      return r;
   endfunction
   function automatic int width_of(input int v);
      return (clog2(v) < 1) ? 1 : clog2(v);
   endfunction
   function automatic int half(input int clk_hz, input int tone_hz);
      return clk_hz / (2 * tone_hz);
   endfunction
endpackage

// File: rtl/sync_rise.sv
// sync_rise: two-flop synchronizer with a third flop for rising-edge detection
module sync_rise
   import buzz_pkg::*;
(
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic level,
   output logic rise
);
   logic s1, s2, s3;
   // shift the asynchronous input through the synchronizer and edge flop
   always_ff @(posedge clk or posedge rst)
      if (rst) {s1, s2, s3} <= 3'b000;
      else {s1, s2, s3} <= {d, s1, s2};
   assign level = s2;
   assign rise = s2 & ~s3;
endmodule

// File: rtl/buzz_alarm.sv
// buzz_alarm: alarm buzzer driver; optional BUZZ_PULSE_EN gates the tone with clk1hz for a beep-beep pattern
module buzz_alarm
   import buzz_pkg::*;
#(
   parameter int CLK_HZ = CLK_HZ_DEF,
   parameter int TONE_HZ = TONE_HZ_DEF,
   parameter int BEEP_SECS = BEEP_SECS_DEF
) (
   input  logic clk50mhz,
   input  logic rst,
   input  logic clk1hz,
   input  logic beepen,
   output logic b_eep
);
   localparam int HALF = half(CLK_HZ, TONE_HZ);
   localparam int CW = width_of(HALF);
   localparam int RW = width_of(BEEP_SECS + 1);
   localparam logic [CW-1:0] CNT_MAX = CW'(HALF - 1);
   localparam logic [RW-1:0] REM_LOAD = RW'(BEEP_SECS);
   localparam logic [RW-1:0] REM_ONE = RW'(1);
   state_t state;
   logic [RW-1:0] remaining;
   logic [CW-1:0] cnt, cnt_nx;
   logic phase, phase_nx, wrap, gate;
   logic b_level, b_rise, c_level, c_rise;
   sync_rise u_beep (.clk(clk50mhz), .rst, .d(beepen), .level(b_level), .rise(b_rise));
   sync_rise u_tick (.clk(clk50mhz), .rst, .d(clk1hz), .level(c_level), .rise(c_rise));
`ifdef BUZZ_PULSE_EN
   logic unused_level;
   assign gate = c_level;
   assign unused_level = b_level;
`else
   logic unused_levels;
   assign gate = 1'b1;
   assign unused_levels = b_level ^ c_level;
`endif
   // free-running tone divider step: wrap at HALF-1 and flip the phase
   always_comb begin
      wrap = cnt == CNT_MAX;
      cnt_nx = wrap ? '0 : cnt + CW'(1);
      phase_nx = wrap ? ~phase : phase;
   end
   // session control: start/reload beats ticks, last tick silences the buzzer on the same edge
   always_ff @(posedge clk50mhz or posedge rst)
      if (rst) begin
         state <= IDLE;
         remaining <= '0;
         cnt <= '0;
         phase <= 1'b0;
         b_eep <= 1'b0;
      end else if (b_rise) begin
         state <= BEEP;
         remaining <= REM_LOAD;
         if (state == IDLE) begin
            cnt <= '0;
            phase <= 1'b1;
            b_eep <= gate;
         end else begin
            cnt <= cnt_nx;
            phase <= phase_nx;
            b_eep <= phase_nx & gate;
         end
      end else if (state == BEEP) begin
         if (c_rise && remaining == REM_ONE) begin
            state <= IDLE;
            remaining <= '0;
            cnt <= '0;
            phase <= 1'b0;
            b_eep <= 1'b0;
         end else begin
            if (c_rise) remaining <= remaining - REM_ONE;
            cnt <= cnt_nx;
            phase <= phase_nx;
            b_eep <= phase_nx & gate;
         end
      end
endmodule

// File: tb/tb_buzz_alarm.sv
// tb_buzz_alarm: directed plus randomized checks of buzz_alarm against a cycle-indexed behavioural model
module tb_buzz_alarm;
   localparam int HALF = 4;
   localparam int SECS = 3;
   logic clk50mhz = 0, rst = 1, clk1hz = 0, beepen = 0;
   logic b_eep;
   int checks = 0, errors = 0;
   buzz_alarm #(.CLK_HZ(8), .TONE_HZ(1), .BEEP_SECS(SECS)) dut (
      .clk50mhz(clk50mhz), .rst(rst), .clk1hz(clk1hz), .beepen(beepen), .b_eep(b_eep)
   );
   always #5 clk50mhz = ~clk50mhz;
   initial begin
      #3_000_000;
      $display("FAIL watchdog: run did not finish in time");
      $fatal(1, "watchdog");
   end
   task automatic check(input string name, input logic act, input logic exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s at t=%0t: b_eep=%b, required %b", name, $time, act, exp);
      end
   endtask
   // model: inputs recorded per edge; a request first seen at edge k acts at edge k+2
   bit bh [0:99999];
   bit ch [0:99999];
   int cyc = 0, m_rem = 0, m_start = 0;
   bit m_act = 0, m_exp = 0, br, cr;
   always @(posedge clk50mhz) begin
      cyc++;
      if (rst) begin
         for (int j = 0; j < 3; j++)
            if (cyc - j >= 0) begin
               bh[cyc-j] = 0;
               ch[cyc-j] = 0;
            end
         m_act = 0;
         m_rem = 0;
      end else begin
         bh[cyc] = beepen;
         ch[cyc] = clk1hz;
         br = cyc >= 3 && bh[cyc-2] && !bh[cyc-3];
         cr = cyc >= 3 && ch[cyc-2] && !ch[cyc-3];
         if (br) begin
            if (!m_act) m_start = cyc;
            m_act = 1;
            m_rem = SECS;
         end else if (m_act && cr) begin
            m_rem--;
            if (m_rem == 0) m_act = 0;
         end
      end
      m_exp = m_act && (((cyc - m_start) / HALF) % 2 == 0);
`ifdef BUZZ_PULSE_EN
      if (cyc >= 2 && !ch[cyc-2]) m_exp = 0;
`endif
      #1;
      check("model", b_eep, m_exp);
   end
   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk50mhz);
         #2;
      end
   endtask
   task automatic tick();
      clk1hz = 0;
      step(4);
      clk1hz = 1;
      step(4);
   endtask
   task automatic last_tick(input string name);
      clk1hz = 0;
      step(4);
      clk1hz = 1;
      step(3);
      check(name, b_eep, 1'b0);
      step(1);
   endtask
   task automatic alive(input string name);
      logic seen;
      seen = 0;
      for (int i = 0; i < 2 * HALF; i++) begin
         step(1);
         if (b_eep) seen = 1;
      end
      check(name, seen, 1'b1);
   endtask
   task automatic pulse();
      beepen = 1;
      step(2);
      beepen = 0;
   endtask
   int b_cnt, c_cnt;
   logic found;
   initial begin
      step(4);
      check("reset_hold", b_eep, 1'b0);
      rst = 0;
      for (int i = 0; i < 1000; i++) begin
         if (i % 10 == 0) clk1hz = ~clk1hz;
         step(1);
      end
      check("idle_1000", b_eep, 1'b0);
      clk1hz = 1;
      step(8);
      beepen = 1;
      step(1);
      check("start_n", b_eep, 1'b0);
      step(1);
      check("start_n1", b_eep, 1'b0);
      beepen = 0;
      for (int i = 0; i < 12; i++) begin
         step(1);
         check("tone_shape", b_eep, ((i / HALF) % 2) == 0);
      end
      tick();
      tick();
      alive("before_third_tick");
      last_tick("end_after_third");
      clk1hz = 0;
      step(20);
      check("stays_off", b_eep, 1'b0);
      clk1hz = 1;
      step(4);
      pulse();
      step(10);
      tick();
      tick();
      pulse();
      step(6);
      tick();
      alive("retrig_survives");
      tick();
      last_tick("retrig_end");
      pulse();
      step(10);
      tick();
      clk1hz = 0;
      step(4);
      clk1hz = 1;
      beepen = 1;
      step(2);
      beepen = 0;
      step(2);
      tick();
      tick();
      alive("coinc_tick_ignored");
      last_tick("coinc_end");
      pulse();
      found = 0;
      for (int i = 0; i < 20 && !found; i++) begin
         step(1);
         if (b_eep) found = 1;
      end
      check("async_wait_high", found, 1'b1);
      @(posedge clk50mhz);
      #3 rst = 1;
      #1 check("async_rst_now", b_eep, 1'b0);
      step(3);
      rst = 0;
      for (int i = 0; i < 60; i++) begin
         if (i % 6 == 0) clk1hz = ~clk1hz;
         step(1);
      end
      check("post_rst_quiet", b_eep, 1'b0);
      b_cnt = 0;
      c_cnt = 0;
      for (int i = 0; i < 5000; i++) begin
         if (b_cnt == 0) begin
            beepen = ~beepen;
            b_cnt = beepen ? $urandom_range(2, 20) : $urandom_range(2, 200);
         end
         if (c_cnt == 0) begin
            clk1hz = ~clk1hz;
            c_cnt = $urandom_range(3, 20);
         end
         rst = $urandom_range(0, 999) == 0;
         b_cnt--;
         c_cnt--;
         step(1);
      end
      rst = 0;
      beepen = 0;
      step(5);
      $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
      $finish;
   end
endmodule
